sdram_sched: RTL
================

// Module: sdram_sched
// PURPOSE
//  Shares the single SDRAM command engine between three requesters: ch0 (CPU/PRG), ch1 (PPU/CHR), ch2 (API/QSPI loader).
//  Also owns the auto-refresh schedule: a periodic timer, plus an early "refresh" hint from the mapper when the cart bus is idle.
//  Sits between the mapper/API channel logic and the sdram command/timing engine, in the clk domain.
// PARAMETERS
//  ADDR_BITS      22   word address width (row+col+bank)
//  REFRESH_CYCLES 780  clk cycles between mandatory refreshes (7.8 us @ 100 MHz)
//  STARVE_LIMIT   16   lost arbitrations after which ch2 is promoted above ch0/ch1
// PORTS
//  clk             in   1          system clock
//  async_nreset    in   1          asynchronous active-low reset
//  chN_req         in   1          N=0..2; request, held high until chN_done
//  chN_we          in   1          N=0..2; 1=write, 0=read
//  chN_addr        in   ADDR_BITS  N=0..2; word address
//  chN_wdata       in   16         N=0..2; write data
//  chN_rdata       out  16         N=0..2; read data, valid in the chN_done cycle
//  chN_done        out  1          N=0..2; one-cycle completion pulse
//  refresh_hint    in   1          mapper idle-bus pulse; refresh may be done now
//  mem_req         out  1          one-cycle command strobe to the engine
//  mem_ref         out  1          one-cycle refresh strobe to the engine
//  mem_we          out  1          registered write flag
//  mem_addr        out  ADDR_BITS  registered address
//  mem_wdata       out  16         registered write data
//  mem_rdata       in   16         engine read data, valid with mem_done
//  mem_done        in   1          engine completion pulse (access or refresh)
//  ref_overrun     out  1          sticky: timer expired while a refresh was already pending
// BEHAVIOUR
//  - Reset (async, while async_nreset=0): state=IDLE; all outputs 0; ref_pending=0; starve=0; timer=REFRESH_CYCLES-1.
//  - FSM states: IDLE, ISSUE, WAIT, REFRESH.
//  - IDLE arbitration, evaluated every cycle. Priority:
//    ref_pending > ch2 (if starve==STARVE_LIMIT) > ch0 > ch1 > ch2.
//  - IDLE, channel N granted: latch N, chN_we, chN_addr, chN_wdata into the mem_* registers -> ISSUE.
//  - ISSUE: mem_req=1 for exactly 1 cycle -> WAIT. A request seen in IDLE at cycle t gives mem_req at t+1.
//  - WAIT: hold mem_* stable until mem_done.
//    On mem_done: chN_rdata<=mem_rdata (reads only; writes leave rdata unchanged).
//    chN_done pulses in the next cycle -> IDLE.
//    Minimum turnaround: chN_done at cycle d, next grant no earlier than d (IDLE re-entered with chN_done).
//  - IDLE, refresh chosen: mem_ref=1 for 1 cycle, clear ref_pending -> REFRESH; wait for mem_done -> IDLE.
//  - Refresh timer: counts down every cycle.
//    At 0: reload REFRESH_CYCLES-1 and set ref_pending; if ref_pending was already 1, set ref_overrun (sticky until reset).
//    refresh_hint=1: set ref_pending and reload the timer. A hint while pending is harmless (no overrun).
//    Timer expiry and hint in the same cycle: a single pending and a single reload.
//  - A refresh never preempts an in-flight access; it waits for IDLE.
//  - Starvation counter (saturating, width clog2(STARVE_LIMIT+1)):
//    +1 on each IDLE grant to ch0/ch1 while ch2_req=1.
//    Cleared when ch2 is granted or when ch2_req=0.
//  - A requester dropping req mid-transaction is a protocol violation; the access still completes and chN_done still pulses.
//  - mem_done outside WAIT/REFRESH is ignored. At most one transaction is outstanding.
//  - chN_done is never asserted for more than one channel in the same cycle.
// TESTING
//  1. Reset release, ch0_req=1 read addr 0x1234 -> mem_req at +1, mem_addr=0x1234, mem_we=0.
//     mem_done with rdata 0xBEEF -> ch0_done 1 cycle later, ch0_rdata=0xBEEF.
//  2. ch0, ch1, ch2 requesting simultaneously, engine done in 3 cycles -> grants in order ch0, ch1, ch2.
//     Each gets exactly one done pulse.
//  3. ch0 re-requesting continuously, ch2_req held -> ch2 granted after the 16th ch0 grant; starve returns to 0.
//  4. REFRESH_CYCLES=20, no traffic -> mem_ref every 20 cycles.
//     refresh_hint at cycle 5 -> mem_ref at 6, next timer refresh 20 cycles after the hint.
//  5. REFRESH_CYCLES=8, engine stalls mem_done for 20 cycles during a ch1 access -> ref_overrun=1.
//     Exactly one mem_ref after ch1_done.
//  6. Assert async_nreset=0 during WAIT -> all outputs 0 immediately.
//     After release, a new ch1 request is served normally and the stale mem_done is ignored.

Source files
------------

// File: rtl/sdram_sched.sv
// Three-way SDRAM command arbiter with auto-refresh scheduling.
// ch2 is promoted above ch0/ch1 once it has lost STARVE_LIMIT arbitrations in a row.
module sdram_sched #(
    parameter int ADDR_BITS      = 22,
    parameter int REFRESH_CYCLES = 780,
    parameter int STARVE_LIMIT   = 16
) (
    input  logic                 clk,
    input  logic                 async_nreset,
    input  logic                 ch0_req,
    input  logic                 ch0_we,
    input  logic [ADDR_BITS-1:0] ch0_addr,
    input  logic [15:0]          ch0_wdata,
    output logic [15:0]          ch0_rdata,
    output logic                 ch0_done,
    input  logic                 ch1_req,
    input  logic                 ch1_we,
    input  logic [ADDR_BITS-1:0] ch1_addr,
    input  logic [15:0]          ch1_wdata,
    output logic [15:0]          ch1_rdata,
    output logic                 ch1_done,
    input  logic                 ch2_req,
    input  logic                 ch2_we,
    input  logic [ADDR_BITS-1:0] ch2_addr,
    input  logic [15:0]          ch2_wdata,
    output logic [15:0]          ch2_rdata,
    output logic                 ch2_done,
    input  logic                 refresh_hint,
    output logic                 mem_req,
    output logic                 mem_ref,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_wdata,
    input  logic [15:0]          mem_rdata,
    input  logic                 mem_done,
    output logic                 ref_overrun
);
    localparam int TW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REFRESH} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_chan;
    logic                   r_mem_we;
    logic [ADDR_BITS-1:0]   r_mem_addr;
    logic [15:0]            r_mem_wdata;
    logic                   r_mem_ref;
    logic [2:0]             r_done;
    logic [15:0]            r_rdata [3];
    logic                   r_ref_pending;
    logic                   r_overrun;
    logic [TW-1:0]          r_timer;
    logic [SW-1:0]          r_starve;

    logic [2:0]             w_req;
    logic [2:0]             w_we;
    logic [ADDR_BITS-1:0]   w_addr [3];
    logic [15:0]            w_wdata [3];
    logic                   w_tmr_zero;
    logic                   w_ref_now;
    logic                   w_grant;
    logic [1:0]             w_grant_ch;
    logic                   w_do_ref;

    assign w_req      = {ch2_req, ch1_req, ch0_req};
    assign w_we       = {ch2_we, ch1_we, ch0_we};
    assign w_addr[0]  = ch0_addr;
    assign w_addr[1]  = ch1_addr;
    assign w_addr[2]  = ch2_addr;
    assign w_wdata[0] = ch0_wdata;
    assign w_wdata[1] = ch1_wdata;
    assign w_wdata[2] = ch2_wdata;

    // A hint or expiry arriving this cycle is serviced at once, as if already pending.
    assign w_tmr_zero = (r_timer == '0);
    assign w_ref_now  = r_ref_pending | refresh_hint | w_tmr_zero;

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_ch   = 2'd0;
        w_do_ref     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ref_now) begin
                    w_do_ref     = 1'b1;
                    w_state_next = S_REFRESH;
                end else if (w_req[2] && (r_starve == STARVE_MAX)) begin
                    w_grant      = 1'b1;
                    w_grant_ch   = 2'd2;
                    w_state_next = S_ISSUE;
                end else if (w_req[0]) begin
                    w_grant      = 1'b1;
                    w_grant_ch   = 2'd0;
                    w_state_next = S_ISSUE;
                end else if (w_req[1]) begin
                    w_grant      = 1'b1;
                    w_grant_ch   = 2'd1;
                    w_state_next = S_ISSUE;
                end else if (w_req[2]) begin
                    w_grant      = 1'b1;
                    w_grant_ch   = 2'd2;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE:   w_state_next = S_WAIT;
            S_WAIT:    if (mem_done) w_state_next = S_IDLE;
            S_REFRESH: if (mem_done) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_state       <= S_IDLE;
            r_chan        <= 2'd0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_ref     <= 1'b0;
            r_done        <= '0;
            r_rdata[0]    <= '0;
            r_rdata[1]    <= '0;
            r_rdata[2]    <= '0;
            r_ref_pending <= 1'b0;
            r_overrun     <= 1'b0;
            r_timer       <= TMR_RELOAD;
            r_starve      <= '0;
        end else begin
            r_state   <= w_state_next;
            r_mem_ref <= w_do_ref;
            r_done    <= '0;
            if (w_grant) begin
                r_chan      <= w_grant_ch;
                r_mem_we    <= w_we[w_grant_ch];
                r_mem_addr  <= w_addr[w_grant_ch];
                r_mem_wdata <= w_wdata[w_grant_ch];
            end
            if ((r_state == S_WAIT) && mem_done) begin
                r_done[r_chan] <= 1'b1;
                if (!r_mem_we) r_rdata[r_chan] <= mem_rdata;
            end

            if (refresh_hint || w_tmr_zero) r_timer <= TMR_RELOAD;
            else                            r_timer <= r_timer - TW'(1);
            if (w_tmr_zero && r_ref_pending) r_overrun <= 1'b1;
            if (w_do_ref)                           r_ref_pending <= 1'b0;
            else if (refresh_hint || w_tmr_zero)    r_ref_pending <= 1'b1;

            if (!w_req[2] || (w_grant && (w_grant_ch == 2'd2))) r_starve <= '0;
            else if (w_grant && (r_starve != STARVE_MAX))      r_starve <= r_starve + SW'(1);
        end
    end

    assign mem_req     = (r_state == S_ISSUE);
    assign mem_ref     = r_mem_ref;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign ref_overrun = r_overrun;
    assign ch0_rdata   = r_rdata[0];
    assign ch1_rdata   = r_rdata[1];
    assign ch2_rdata   = r_rdata[2];
    assign ch0_done    = r_done[0];
    assign ch1_done    = r_done[1];
    assign ch2_done    = r_done[2];
endmodule
